channel_err_inj: RTL and testbench
==================================

CHANNEL_ERR_INJ -- requirements
Module: channel_err_inj

Interface
REQ-001 Parameter SEED, default 16'hACE1, reset value of the 16-bit LFSR; a value of 0 SHALL be replaced by 16'h0001.
REQ-002 Parameter MIN_GAP, default 8, number of valid symbols after an injection during which no injection SHALL occur (range 1..255).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 enable_i  in  1  symbol valid from the convolutional encoder.
REQ-006 sym_i  in  2  encoded rate-1/2 symbol {d1,d0}.
REQ-007 mode_i  in  2  00 off, 01 random, 10 periodic, 11 one-shot.
REQ-008 thresh_i  in  8  random mode: inject when lfsr[7:0] < thresh_i.
REQ-009 period_i  in  8  periodic mode: inject once every period_i valid symbols.
REQ-010 sym_o  out  2  symbol to the Viterbi decoder, equal to sym_i XOR err_inj.
REQ-011 valid_o  out  1  sym_o valid.
REQ-012 err_inj  out  2  error mask applied to the current sym_o.
REQ-013 word_ct  out  12  count of valid symbols passed.
REQ-014 error_counter  out  12  count of injected symbol errors.

Function
REQ-015 All outputs SHALL be registered, with exactly 1-cycle latency: a symbol sampled with enable_i=1 on edge N appears on sym_o/valid_o/err_inj after edge N.
REQ-016 On a cycle with enable_i=0, valid_o SHALL be 0, sym_o and err_inj SHALL be 0, and no state (LFSR, counters, FSM) SHALL change.
REQ-017 The 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) SHALL advance once per valid symbol; the injection decision SHALL use its value before the advance.
REQ-018 Injection mask: random mode uses lfsr[9] ? 2'b10 : 2'b01; periodic and one-shot modes use 2'b01; only single-bit errors SHALL be injected.
REQ-019 FSM states: IDLE (mode 00 or one-shot spent), ARMED (eligible to inject), GAP (counting down MIN_GAP valid symbols).
REQ-020 ARMED -> GAP on injection, with the gap counter loaded to MIN_GAP; GAP -> ARMED when the counter reaches 0 on a valid symbol; any state -> IDLE when mode_i=00.
REQ-021 In GAP, the gap counter SHALL decrement per valid symbol, and injection SHALL be suppressed even if the mode condition is true.
REQ-022 The periodic counter SHALL increment per valid symbol and wrap at period_i-1; injection SHALL occur at the wrap only if the FSM is in ARMED; period_i=0 or 1 SHALL disable periodic injection.
REQ-023 One-shot SHALL inject on the first ARMED valid symbol after mode_i becomes 11, then go to IDLE; it re-arms only after mode_i leaves 11 and returns.
REQ-024 A mode_i change SHALL take effect on the next valid symbol; a gap countdown in progress SHALL continue across the change, except on a change to 00.
REQ-025 thresh_i=0 SHALL never inject; thresh_i=255 SHALL inject whenever ARMED and lfsr[7:0]!=255.
REQ-026 word_ct SHALL increment per valid symbol and wrap 4095 -> 0.
REQ-027 error_counter SHALL increment per injection and saturate at 4095.

Reset
REQ-028 rst=0 SHALL immediately force sym_o=0, valid_o=0, err_inj=0, word_ct=0, error_counter=0, FSM=IDLE, gap and period counters=0, LFSR=SEED, independent of clk.
REQ-029 After rst deasserts, the first valid symbol SHALL be evaluated from IDLE/ARMED per mode_i; reset asserted mid-gap or mid-period SHALL discard all history.

Verification
REQ-030 mode 00, 100 valid symbols of alternating 2'b01/2'b10 -> sym_o equals sym_i delayed 1 cycle, err_inj=0, word_ct=100, error_counter=0.
REQ-031 mode 10, period_i=4, MIN_GAP=2, 40 valid symbols -> injections on symbols 3,7,...,39 (0-based), error_counter=10, err_inj=2'b01 on those symbols only.
REQ-032 mode 10, period_i=2, MIN_GAP=8 -> the gap suppresses injections: spacing between injected symbols is at least 9 symbols and a multiple of 2.
REQ-033 mode 11 held for 50 symbols, then 00 for 1 symbol, then 11 -> exactly 2 injections, error_counter=2.
REQ-034 mode 01, thresh_i=255, SEED default, 4100 symbols -> word_ct=4, error_counter matches the reference LFSR model, and no two injections are closer than MIN_GAP+1 symbols.
REQ-035 Assert rst mid-gap with enable_i toggling -> outputs go to 0 asynchronously, and after release the LFSR sequence restarts from SEED.

Source files
------------

// File: rtl/channel_err_inj_if.sv
// rtl/channel_err_inj_if.sv - symbol stream and control bundle for channel_err_inj
interface channel_err_inj_if;
  logic        enable_i;
  logic [1:0]  sym_i;
  logic [1:0]  mode_i;
  logic [7:0]  thresh_i;
  logic [7:0]  period_i;
  logic [1:0]  sym_o;
  logic        valid_o;
  logic [1:0]  err_inj;
  logic [11:0] word_ct;
  logic [11:0] error_counter;

  modport master (
    output enable_i, sym_i, mode_i, thresh_i, period_i,
    input  sym_o, valid_o, err_inj, word_ct, error_counter
  );

  modport slave (
    input  enable_i, sym_i, mode_i, thresh_i, period_i,
    output sym_o, valid_o, err_inj, word_ct, error_counter
  );
endinterface

// File: rtl/channel_err_inj.sv
// rtl/channel_err_inj.sv - single-bit error injector between convolutional encoder and Viterbi decoder
module channel_err_inj #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          MIN_GAP = 8
) (
  input  logic              clk,
  input  logic              rst,
  channel_err_inj_if.slave  ch
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [1:0]  MODE_OFF      = 2'b00;
  localparam logic [1:0]  MODE_RANDOM   = 2'b01;
  localparam logic [1:0]  MODE_PERIODIC = 2'b10;
  localparam logic [1:0]  MODE_ONESHOT  = 2'b11;
  localparam logic [15:0] SEED_INIT     = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [7:0]  GAP_LOAD      = 8'(MIN_GAP);
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [11:0] CNT_MAX       = 12'hFFF;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]  per_cnt_q, per_cnt_d;
  logic        os_spent_q, os_spent_d;
  logic [1:0]  sym_q, sym_d;
  logic        valid_q, valid_d;
  logic [1:0]  err_q, err_d;
  logic [11:0] word_ct_q, word_ct_d;
  logic [11:0] err_cnt_q, err_cnt_d;

  logic        armed;
  logic        per_hit;
  logic        inject;
  logic [1:0]  mask;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    gap_cnt_d  = gap_cnt_q;
    per_cnt_d  = per_cnt_q;
    os_spent_d = os_spent_q;
    word_ct_d  = word_ct_q;
    err_cnt_d  = err_cnt_q;
    sym_d      = 2'b00;
    valid_d    = 1'b0;
    err_d      = 2'b00;
    armed      = 1'b0;
    per_hit    = 1'b0;
    inject     = 1'b0;
    mask       = 2'b00;

    if (ch.enable_i) begin
      valid_d   = 1'b1;
      word_ct_d = word_ct_q + 12'd1;
      lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

      // Periods below 2 have no meaningful wrap point, so the counter is parked.
      if (ch.period_i < 8'd2) begin
        per_cnt_d = 8'd0;
      end else if (per_cnt_q >= ch.period_i - 8'd1) begin
        per_cnt_d = 8'd0;
        per_hit   = 1'b1;
      end else begin
        per_cnt_d = per_cnt_q + 8'd1;
      end

      if (ch.mode_i != MODE_ONESHOT) begin
        os_spent_d = 1'b0;
      end

      unique case (state_q)
        ARMED:   armed = 1'b1;
        IDLE:    armed = !((ch.mode_i == MODE_ONESHOT) && os_spent_q);
        default: armed = 1'b0;
      endcase
      if (ch.mode_i == MODE_OFF) begin
        armed = 1'b0;
      end

      unique case (ch.mode_i)
        MODE_RANDOM: begin
          inject = armed && (lfsr_q[7:0] < ch.thresh_i);
          mask   = lfsr_q[9] ? 2'b10 : 2'b01;
        end
        MODE_PERIODIC: begin
          inject = armed && per_hit;
          mask   = 2'b01;
        end
        MODE_ONESHOT: begin
          inject = armed;
          mask   = 2'b01;
        end
        default: begin
          inject = 1'b0;
          mask   = 2'b00;
        end
      endcase
      if (!inject) begin
        mask = 2'b00;
      end

      // Next state: mode off wins, then injection, then gap countdown.
      if (ch.mode_i == MODE_OFF) begin
        state_d   = IDLE;
        gap_cnt_d = 8'd0;
      end else if (inject) begin
        if (ch.mode_i == MODE_ONESHOT) begin
          state_d    = IDLE;
          os_spent_d = 1'b1;
        end else begin
          state_d   = GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end else if (state_q == GAP) begin
        if (gap_cnt_q <= 8'd1) begin
          gap_cnt_d = 8'd0;
          state_d   = ARMED;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end else if (armed) begin
        state_d = ARMED;
      end

      if (inject && (err_cnt_q != CNT_MAX)) begin
        err_cnt_d = err_cnt_q + 12'd1;
      end

      sym_d = ch.sym_i ^ mask;
      err_d = mask;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED_INIT;
      gap_cnt_q  <= 8'd0;
      per_cnt_q  <= 8'd0;
      os_spent_q <= 1'b0;
      sym_q      <= 2'b00;
      valid_q    <= 1'b0;
      err_q      <= 2'b00;
      word_ct_q  <= 12'd0;
      err_cnt_q  <= 12'd0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      gap_cnt_q  <= gap_cnt_d;
      per_cnt_q  <= per_cnt_d;
      os_spent_q <= os_spent_d;
      sym_q      <= sym_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      word_ct_q  <= word_ct_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign ch.sym_o         = sym_q;
  assign ch.valid_o       = valid_q;
  assign ch.err_inj       = err_q;
  assign ch.word_ct       = word_ct_q;
  assign ch.error_counter = err_cnt_q;

endmodule

// File: tb/tb_channel_err_inj.sv
// tb/tb_channel_err_inj.sv - randomized bench for channel_err_inj against a symbol-level reference model
module tb_channel_err_inj;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  channel_err_inj_if ch0 ();
  channel_err_inj_if ch1 ();

  channel_err_inj u_dut0 (
    .clk (clk),
    .rst (rst_n),
    .ch  (ch0.slave)
  );

  channel_err_inj #(.MIN_GAP(2)) u_dut1 (
    .clk (clk),
    .rst (rst_n),
    .ch  (ch1.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: injection eligibility from distance to last gap-opening injection.
  logic [15:0] m_lfsr;
  int          m_pcnt;
  int          m_idx;
  int          m_words;
  int          m_last[2];
  bit          m_spent[2];
  int          m_errs[2];
  logic        exp_valid;
  logic [1:0]  exp_mask[2];
  logic [1:0]  exp_sym[2];
  int          inj0[$];

  function automatic int gap_of(input int d);
    return (d == 0) ? 8 : 2;
  endfunction

  task automatic model_reset();
    m_lfsr  = SEED;
    m_pcnt  = 0;
    m_idx   = 0;
    m_words = 0;
    for (int d = 0; d < 2; d++) begin
      m_last[d]  = -1000;
      m_spent[d] = 1'b0;
      m_errs[d]  = 0;
    end
    inj0.delete();
  endtask

  task automatic drive(input logic en, input logic [1:0] s, input logic [1:0] m,
                       input logic [7:0] th, input logic [7:0] pe);
    ch0.enable_i = en; ch0.sym_i = s; ch0.mode_i = m; ch0.thresh_i = th; ch0.period_i = pe;
    ch1.enable_i = en; ch1.sym_i = s; ch1.mode_i = m; ch1.thresh_i = th; ch1.period_i = pe;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 8'd0, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step(input logic en, input logic [1:0] s, input logic [1:0] m,
                      input logic [7:0] th, input logic [7:0] pe);
    bit         per_hit, elig, inj;
    logic [1:0] mask;
    logic       gv[2];
    logic [1:0] gs[2], ge[2];
    logic [11:0] gw[2], gc[2];
    @(negedge clk);
    drive(en, s, m, th, pe);
    exp_valid = en;
    for (int d = 0; d < 2; d++) begin
      exp_mask[d] = 2'b00;
      exp_sym[d]  = 2'b00;
    end
    if (en) begin
      per_hit = 1'b0;
      if (pe >= 2) begin
        if (m_pcnt >= int'(pe) - 1) begin
          m_pcnt  = 0;
          per_hit = 1'b1;
        end else begin
          m_pcnt++;
        end
      end else begin
        m_pcnt = 0;
      end
      for (int d = 0; d < 2; d++) begin
        if (m != 2'b11) m_spent[d] = 1'b0;
        elig = (m != 2'b00) && (m_idx - m_last[d] > gap_of(d)) && !(m == 2'b11 && m_spent[d]);
        inj  = 1'b0;
        mask = 2'b01;
        case (m)
          2'b01: begin
            inj  = elig && (m_lfsr[7:0] < th);
            mask = m_lfsr[9] ? 2'b10 : 2'b01;
          end
          2'b10:   inj = elig && per_hit;
          2'b11:   inj = elig;
          default: inj = 1'b0;
        endcase
        if (inj) begin
          exp_mask[d] = mask;
          if (m_errs[d] < 4095) m_errs[d]++;
          if (m == 2'b11) m_spent[d] = 1'b1;
          else            m_last[d]  = m_idx;
        end
        if (m == 2'b00) m_last[d] = -1000;
        exp_sym[d] = s ^ exp_mask[d];
      end
      m_lfsr  = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      m_idx++;
      m_words = (m_words + 1) % 4096;
    end
    @(posedge clk);
    #1;
    gv[0] = ch0.valid_o; gs[0] = ch0.sym_o; ge[0] = ch0.err_inj; gw[0] = ch0.word_ct; gc[0] = ch0.error_counter;
    gv[1] = ch1.valid_o; gs[1] = ch1.sym_o; ge[1] = ch1.err_inj; gw[1] = ch1.word_ct; gc[1] = ch1.error_counter;
    if (en && ge[0] != 2'b00) inj0.push_back(m_idx - 1);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (gv[d] !== exp_valid) $display("FAIL valid_o dut%0d sym%0d got %b exp %b", d, m_idx, gv[d], exp_valid);
      else n_pass++;
      n_checks++;
      if (gs[d] !== exp_sym[d]) $display("FAIL sym_o dut%0d sym%0d got %b exp %b", d, m_idx, gs[d], exp_sym[d]);
      else n_pass++;
      n_checks++;
      if (ge[d] !== exp_mask[d]) $display("FAIL err_inj dut%0d sym%0d got %b exp %b", d, m_idx, ge[d], exp_mask[d]);
      else n_pass++;
      n_checks++;
      if (gw[d] !== 12'(m_words)) $display("FAIL word_ct dut%0d sym%0d got %0d exp %0d", d, m_idx, gw[d], m_words);
      else n_pass++;
      n_checks++;
      if (gc[d] !== 12'(m_errs[d])) $display("FAIL error_counter dut%0d sym%0d got %0d exp %0d", d, m_idx, gc[d], m_errs[d]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 2'b00, 2'b00, 8'd0, 8'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ch0.valid_o, ch0.sym_o, ch0.err_inj, ch0.word_ct, ch0.error_counter} !== 29'd0)
      $display("FAIL reset_dut0 got %h exp 0", {ch0.valid_o, ch0.sym_o, ch0.err_inj, ch0.word_ct, ch0.error_counter});
    else n_pass++;
    n_checks++;
    if ({ch1.valid_o, ch1.sym_o, ch1.err_inj, ch1.word_ct, ch1.error_counter} !== 29'd0)
      $display("FAIL reset_dut1 got %h exp 0", {ch1.valid_o, ch1.sym_o, ch1.err_inj, ch1.word_ct, ch1.error_counter});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_passthrough();
    do_reset();
    for (int i = 0; i < 100; i++) step(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 8'd255, 8'd3);
    n_checks++;
    if (ch0.word_ct !== 12'd100) $display("FAIL pass_word_ct got %0d exp 100", ch0.word_ct);
    else n_pass++;
    n_checks++;
    if (ch0.error_counter !== 12'd0) $display("FAIL pass_err_ct got %0d exp 0", ch0.error_counter);
    else n_pass++;
  endtask

  task automatic test_periodic();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 2'($urandom), 2'b10, 8'd0, 8'd4);
      n_checks++;
      if (ch1.err_inj !== ((i % 4 == 3) ? 2'b01 : 2'b00))
        $display("FAIL per4_pos sym%0d got %b exp %b", i, ch1.err_inj, (i % 4 == 3) ? 2'b01 : 2'b00);
      else n_pass++;
    end
    n_checks++;
    if (ch1.error_counter !== 12'd10) $display("FAIL per4_gap2_count got %0d exp 10", ch1.error_counter);
    else n_pass++;
    n_checks++;
    if (ch0.error_counter !== 12'd4) $display("FAIL per4_gap8_count got %0d exp 4", ch0.error_counter);
    else n_pass++;
  endtask

  task automatic test_periodic_gap();
    do_reset();
    for (int i = 0; i < 60; i++) step(1'b1, 2'($urandom), 2'b10, 8'd0, 8'd2);
    n_checks++;
    if (inj0.size() < 2) $display("FAIL per2_inj_count got %0d exp >=2", inj0.size());
    else n_pass++;
    for (int k = 1; k < inj0.size(); k++) begin
      n_checks++;
      if ((inj0[k] - inj0[k-1] < 9) || ((inj0[k] - inj0[k-1]) % 2 != 0))
        $display("FAIL per2_spacing got %0d exp >=9 and even", inj0[k] - inj0[k-1]);
      else n_pass++;
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    for (int i = 0; i < 50; i++) step(1'b1, 2'($urandom), 2'b11, 8'd0, 8'd0);
    step(1'b1, 2'b00, 2'b00, 8'd0, 8'd0);
    for (int i = 0; i < 20; i++) step(1'b1, 2'($urandom), 2'b11, 8'd0, 8'd0);
    n_checks++;
    if (ch0.error_counter !== 12'd2) $display("FAIL oneshot_dut0 got %0d exp 2", ch0.error_counter);
    else n_pass++;
    n_checks++;
    if (ch1.error_counter !== 12'd2) $display("FAIL oneshot_dut1 got %0d exp 2", ch1.error_counter);
    else n_pass++;
  endtask

  task automatic test_random_full();
    do_reset();
    for (int i = 0; i < 4100; i++) step(1'b1, 2'($urandom), 2'b01, 8'd255, 8'd0);
    n_checks++;
    if (ch0.word_ct !== 12'd4) $display("FAIL rand_word_wrap got %0d exp 4", ch0.word_ct);
    else n_pass++;
    n_checks++;
    if (ch0.error_counter !== 12'(m_errs[0])) $display("FAIL rand_err_ct got %0d exp %0d", ch0.error_counter, m_errs[0]);
    else n_pass++;
    for (int k = 1; k < inj0.size(); k++) begin
      n_checks++;
      if (inj0[k] - inj0[k-1] < 9) $display("FAIL rand_spacing got %0d exp >=9", inj0[k] - inj0[k-1]);
      else n_pass++;
    end
  endtask

  task automatic test_random_mixed();
    logic [1:0] m;
    logic [7:0] th, pe;
    do_reset();
    m = 2'b01; th = 8'd128; pe = 8'd3;
    for (int i = 0; i < 2000; i++) begin
      if (i % 37 == 0) begin
        m  = 2'($urandom);
        th = 8'($urandom);
        pe = 8'($urandom_range(0, 9));
      end
      step(($urandom % 4) != 0, 2'($urandom), m, th, pe);
    end
  endtask

  task automatic test_reset_midgap();
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 2'($urandom), 2'b10, 8'd0, 8'd4);
    step(1'b0, 2'b00, 2'b10, 8'd0, 8'd4);
    step(1'b1, 2'b11, 2'b10, 8'd0, 8'd4);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ch0.valid_o, ch0.sym_o, ch0.err_inj, ch0.word_ct, ch0.error_counter} !== 29'd0)
      $display("FAIL async_rst_dut0 got %h exp 0", {ch0.valid_o, ch0.sym_o, ch0.err_inj, ch0.word_ct, ch0.error_counter});
    else n_pass++;
    n_checks++;
    if ({ch1.valid_o, ch1.sym_o, ch1.err_inj, ch1.word_ct, ch1.error_counter} !== 29'd0)
      $display("FAIL async_rst_dut1 got %h exp 0", {ch1.valid_o, ch1.sym_o, ch1.err_inj, ch1.word_ct, ch1.error_counter});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(i[0], 2'($urandom), 2'b10, 8'd0, 8'd4);
    end
    @(negedge clk);
    drive(1'b0, 2'b00, 2'b00, 8'd0, 8'd0);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 300; i++) step(1'b1, 2'($urandom), 2'b01, 8'd100, 8'd0);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_periodic();
    test_periodic_gap();
    test_oneshot();
    test_random_full();
    test_random_mixed();
    test_reset_midgap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
